// File: rtl/cga_pkg.sv
// rtl/cga_pkg.sv - shared FSM states, register offsets and BIOS CGA mode table
package cga_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        STROBE,
        HOLD,
        NEXT,
        FINISH
    } state_t;

    localparam logic [3:0] OFS_INDEX = 4'd4;
    localparam logic [3:0] OFS_DATA  = 4'd5;
    localparam logic [3:0] OFS_MODE  = 4'd8;
    localparam logic [3:0] OFS_COLOR = 4'd9;

    localparam int         WRITE_COUNT  = 35;
    localparam logic [5:0] LAST_STEP    = 6'(WRITE_COUNT - 1);
    localparam logic [2:0] MODE_INVALID = 3'd7;

    // CRTC R0 is the most significant byte of each 128-bit row
    localparam logic [127:0] CRTC_40  = 128'h38282D0A1F06191C0207060700000000;
    localparam logic [127:0] CRTC_80  = 128'h71505A0A1F06191C0207060700000000;
    localparam logic [127:0] CRTC_GFX = 128'h38282D0A7F0664700201060700000000;

    typedef struct packed {
        logic [7:0]   ctrl;
        logic [7:0]   color;
        logic [127:0] crtc;
    } mode_entry_t;

    // Entry 7 (invalid mode) is all zeros so a 3-bit mode can index without a range guard
    localparam mode_entry_t MODE_TABLE [0:7] = '{
        '{8'h2C, 8'h30, CRTC_40},
        '{8'h28, 8'h30, CRTC_40},
        '{8'h2D, 8'h30, CRTC_80},
        '{8'h29, 8'h30, CRTC_80},
        '{8'h2A, 8'h30, CRTC_GFX},
        '{8'h2E, 8'h30, CRTC_GFX},
        '{8'h1E, 8'h3F, CRTC_GFX},
        '{8'h00, 8'h00, 128'h0}
    };

endpackage

// File: rtl/cga_mode_rom.sv
// rtl/cga_mode_rom.sv - combinational (mode, step) to (register offset, data) lookup
module cga_mode_rom
    import cga_pkg::*;
(
    input  logic [2:0] mode,
    input  logic [5:0] step,
    output logic [3:0] offset,
    output logic [7:0] data
);

    mode_entry_t entry;
    logic [3:0]  reg_idx;
    logic [3:0]  reg_rev;
    logic [7:0]  crtc_byte;

    always_comb begin
        entry     = MODE_TABLE[mode];
        reg_idx   = 4'((step - 6'd1) >> 1);
        reg_rev   = 4'd15 - reg_idx;
        crtc_byte = 8'(entry.crtc >> {reg_rev, 3'b000});
        offset    = OFS_MODE;
        data      = entry.ctrl;
        if (step == 6'd0) begin
            // Blank the display while the CRTC is being reprogrammed
            offset = OFS_MODE;
            data   = entry.ctrl & ~8'h08;
        end else if (step <= 6'd32) begin
            offset = step[0] ? OFS_INDEX : OFS_DATA;
            data   = step[0] ? {4'h0, reg_idx} : crtc_byte;
        end else if (step == 6'd33) begin
            offset = OFS_COLOR;
            data   = entry.color;
        end
    end

endmodule

// File: rtl/cga_mode_init.sv
// rtl/cga_mode_init.sv - programs a BIOS CGA mode through a sequence of ISA IO writes
module cga_mode_init
    import cga_pkg::*;
#(
    parameter logic [15:0] IO_BASE_ADDR = 16'h3D0,
    parameter int          IOW_PULSE    = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  mode,
    input  logic        bus_rdy,
    output logic [14:0] bus_a,
    output logic [7:0]  bus_d,
    output logic        bus_iow_l,
    output logic        bus_ior_l,
    output logic        bus_aen,
    output logic        busy,
    output logic        done,
    output logic        error
);

    localparam logic [3:0]  PULSE_LAST = 4'(IOW_PULSE - 1);
    localparam logic [14:0] BASE       = IO_BASE_ADDR[14:0];

    state_t     state, state_n;
    logic [5:0] step, step_n;
    logic [2:0] mode_q, rom_mode;
    logic [3:0] cnt;
    logic [3:0] rom_offset;
    logic [7:0] rom_data;
    logic       accept;

    assign bus_ior_l = 1'b1;
    assign accept    = (state == IDLE) && start;

    // The ROM looks at the step/mode about to be used so SETUP sees fresh values
    cga_mode_rom u_rom (
        .mode   (rom_mode),
        .step   (step_n),
        .offset (rom_offset),
        .data   (rom_data)
    );

    always_comb begin
        state_n  = state;
        step_n   = step;
        rom_mode = mode_q;
        case (state)
            IDLE: begin
                if (start) begin
                    rom_mode = mode;
                    step_n   = 6'd0;
                    state_n  = (mode == MODE_INVALID) ? FINISH : SETUP;
                end
            end
            SETUP:  state_n = STROBE;
            STROBE: if (cnt == PULSE_LAST && bus_rdy) state_n = HOLD;
            HOLD:   state_n = (step == LAST_STEP) ? FINISH : NEXT;
            NEXT: begin
                step_n  = step + 6'd1;
                state_n = SETUP;
            end
            FINISH:  state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            step      <= 6'd0;
            mode_q    <= 3'd0;
            cnt       <= 4'd0;
            bus_a     <= 15'd0;
            bus_d     <= 8'd0;
            bus_iow_l <= 1'b1;
            bus_aen   <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
        end else begin
            state <= state_n;
            step  <= step_n;
            if (state != STROBE)
                cnt <= 4'd0;
            else if (cnt != PULSE_LAST)
                cnt <= cnt + 4'd1;
            if (accept) begin
                mode_q <= mode;
                error  <= (mode == MODE_INVALID);
            end
            if (state_n == SETUP && state != SETUP) begin
                bus_a <= BASE + {11'd0, rom_offset};
                bus_d <= rom_data;
            end
            bus_iow_l <= (state_n != STROBE);
            bus_aen   <= (state_n == IDLE);
            busy      <= (state_n != IDLE);
            done      <= (state == FINISH);
        end
    end

endmodule

// File: tb/tb_cga_mode_init.sv
// tb/tb_cga_mode_init.sv - directed self-checking bench for cga_mode_init
module tb_cga_mode_init;

    logic        clk = 1'b0;
    logic        reset, start, bus_rdy;
    logic [2:0]  mode;
    logic [14:0] bus_a;
    logic [7:0]  bus_d;
    logic        bus_iow_l, bus_ior_l, bus_aen, busy, done, error;

    always #5 clk = ~clk;

    cga_mode_init #(.IO_BASE_ADDR(16'h3D0), .IOW_PULSE(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .mode      (mode),
        .bus_rdy   (bus_rdy),
        .bus_a     (bus_a),
        .bus_d     (bus_d),
        .bus_iow_l (bus_iow_l),
        .bus_ior_l (bus_ior_l),
        .bus_aen   (bus_aen),
        .busy      (busy),
        .done      (done),
        .error     (error)
    );

    int checks = 0;
    int errors = 0;
    int cyc, nwr, falls, done_cnt, done_cyc, run, stab_err;
    logic        prev_iow = 1'b1;
    logic [14:0] lat_a;
    logic [7:0]  lat_d;
    logic [14:0] wa [0:63];
    logic [7:0]  wd [0:63];
    int          wlen [0:63];
    logic [7:0]  t_ctrl, t_color;
    logic [3:0]  t_idx;
    logic [7:0]  t_crtc [0:15];
    logic [7:0]  exp_crtc3 [0:15] = '{8'h71, 8'h50, 8'h5A, 8'h0A, 8'h1F, 8'h06, 8'h19, 8'h1C,
                                      8'h02, 8'h07, 8'h06, 8'h07, 8'h00, 8'h00, 8'h00, 8'h00};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock, sampled 1 ns after the edge; also acts as bus monitor and CGA target
    task tick();
        @(posedge clk);
        #1;
        cyc++;
        if (!bus_iow_l && prev_iow) begin
            falls++;
            lat_a = bus_a;
            lat_d = bus_d;
            run   = 0;
        end
        if (!bus_iow_l) begin
            run++;
            if (bus_a !== lat_a || bus_d !== lat_d) stab_err++;
        end
        if (bus_iow_l && !prev_iow && nwr < 64) begin
            wa[nwr]   = bus_a;
            wd[nwr]   = bus_d;
            wlen[nwr] = run;
            nwr++;
            case (bus_a)
                15'h3D8: t_ctrl  = bus_d;
                15'h3D9: t_color = bus_d;
                15'h3D4: t_idx   = bus_d[3:0];
                15'h3D5: t_crtc[t_idx] = bus_d;
                default: ;
            endcase
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        prev_iow = bus_iow_l;
    endtask

    task start_seq(input logic [2:0] m);
        nwr = 0; falls = 0; done_cnt = 0; done_cyc = -1; stab_err = 0;
        mode  = m;
        start = 1'b1;
        tick();
        start = 1'b0;
        cyc   = 0;
    endtask

    task wait_done(input int budget);
        int n;
        n = 0;
        while (done_cnt == 0 && n < budget) begin
            tick();
            n++;
        end
        check("done_seen", done_cnt != 0, 1);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; mode = 3'd0; bus_rdy = 1'b1;
        cyc = 0; nwr = 0; falls = 0; done_cnt = 0; done_cyc = -1; run = 0; stab_err = 0;
        t_idx = 4'd0; t_ctrl = 8'd0; t_color = 8'd0;
        repeat (3) tick();
        check("rst_iow_l", bus_iow_l, 1);
        check("rst_ior_l", bus_ior_l, 1);
        check("rst_aen", bus_aen, 1);
        check("rst_a", bus_a, 0);
        check("rst_d", bus_d, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_error", error, 0);
        reset = 1'b0;
        tick();

        // mode 3, no wait states
        start_seq(3'd3);
        check("m3_busy_acc", busy, 1);
        check("m3_aen_acc", bus_aen, 0);
        wait_done(400);
        check("m3_done_cyc", done_cyc, 245);
        check("m3_busy_done", busy, 0);
        check("m3_nwr", nwr, 35);
        check("m3_w0_a", wa[0], 15'h3D8);
        check("m3_w0_d", wd[0], 8'h21);
        check("m3_w1_a", wa[1], 15'h3D4);
        check("m3_w1_d", wd[1], 8'h00);
        check("m3_w2_a", wa[2], 15'h3D5);
        check("m3_w2_d", wd[2], 8'h71);
        check("m3_w33_a", wa[33], 15'h3D9);
        check("m3_w33_d", wd[33], 8'h30);
        check("m3_w34_a", wa[34], 15'h3D8);
        check("m3_w34_d", wd[34], 8'h29);
        check("m3_pulse", wlen[0], 4);
        for (int r = 0; r < 16; r++) check($sformatf("m3_crtc%0d", r), t_crtc[r], exp_crtc3[r]);
        repeat (3) tick();
        check("m3_done_once", done_cnt, 1);
        check("m3_aen_idle", bus_aen, 1);
        check("m3_stable", stab_err, 0);

        // start requests while busy are ignored
        start_seq(3'd3);
        repeat (20) tick();
        mode = 3'd0; start = 1'b1; tick(); start = 1'b0;
        repeat (80) tick();
        mode = 3'd7; start = 1'b1; tick(); start = 1'b0;
        wait_done(400);
        check("bz_nwr", nwr, 35);
        check("bz_done_cyc", done_cyc, 245);
        check("bz_w2_d", wd[2], 8'h71);
        check("bz_w34_d", wd[34], 8'h29);
        check("bz_error", error, 0);
        repeat (2) tick();

        // mode 2 with bus_rdy held low for 10 edges at the end of write 5's pulse
        start_seq(3'd2);
        while (falls < 6 && cyc < 400) tick();
        repeat (3) tick();
        bus_rdy = 1'b0;
        repeat (10) tick();
        bus_rdy = 1'b1;
        wait_done(500);
        check("st_len5", wlen[5], 14);
        check("st_len4", wlen[4], 4);
        check("st_a5", wa[5], 15'h3D4);
        check("st_d5", wd[5], 8'h02);
        check("st_stable", stab_err, 0);
        check("st_done_cyc", done_cyc, 255);
        check("st_ctrl", t_ctrl, 8'h2D);
        repeat (2) tick();

        // invalid mode 7
        start_seq(3'd7);
        check("m7_done_acc", done, 0);
        tick();
        check("m7_done_1", done, 1);
        check("m7_error", error, 1);
        repeat (20) tick();
        check("m7_no_iow", falls, 0);
        check("m7_done_once", done_cnt, 1);
        check("m7_sticky", error, 1);

        // mode 6 read back through the target model
        start_seq(3'd6);
        check("m6_err_clr", error, 0);
        wait_done(400);
        check("m6_ctrl", t_ctrl, 8'h1E);
        check("m6_color", t_color, 8'h3F);
        check("m6_r4", t_crtc[4], 8'h7F);
        check("m6_r6", t_crtc[6], 8'h64);
        check("m6_w0_d", wd[0], 8'h16);
        repeat (2) tick();

        // reset during the strobe of write 10
        start_seq(3'd0);
        while (falls < 11 && cyc < 400) tick();
        tick();
        check("rs_in_strobe", bus_iow_l, 0);
        reset = 1'b1;
        tick();
        check("rs_iow_l", bus_iow_l, 1);
        check("rs_busy", busy, 0);
        check("rs_aen", bus_aen, 1);
        reset = 1'b0;
        repeat (300) tick();
        check("rs_no_done", done_cnt, 0);
        check("rs_no_more", falls, 11);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cga_mode_init.md
CGA_MODE_INIT -- requirements
Module: cga_mode_init

Interface
REQ-001 The block SHALL have parameter IO_BASE_ADDR, default 16'h3D0, meaning the base of the CGA IO window that all writes target.
REQ-002 The block SHALL have parameter IOW_PULSE, default 4, meaning the minimum bus_iow_l low time in clk cycles (legal range 1..15).
REQ-003 The block SHALL have port clk, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port start, input, 1 bit: a one-cycle request to program the mode given on mode.
REQ-006 The block SHALL have port mode, input, 3 bits: the BIOS CGA mode number 0..6, sampled when start is accepted.
REQ-007 The block SHALL have port bus_rdy, input, 1 bit: target ready; while low it extends the current write cycle.
REQ-008 The block SHALL have port bus_a, output, 15 bits: the IO address.
REQ-009 The block SHALL have port bus_d, output, 8 bits: the write data.
REQ-010 The block SHALL have port bus_iow_l, output, 1 bit: the active-low IO write strobe.
REQ-011 The block SHALL have port bus_ior_l, output, 1 bit: held constant 1.
REQ-012 The block SHALL have port bus_aen, output, 1 bit: 0 throughout a sequence, 1 when idle.
REQ-013 The block SHALL have port busy, output, 1 bit: high from start acceptance until done.
REQ-014 The block SHALL have port done, output, 1 bit: a one-cycle completion pulse.
REQ-015 The block SHALL have port error, output, 1 bit: high for invalid mode, sticky until the next accepted start.

Function
REQ-016 The block SHALL accept start only in IDLE; start while busy SHALL be ignored.
REQ-017 The FSM SHALL use states IDLE, SETUP, STROBE, HOLD, NEXT, FINISH.
REQ-018 Each write SHALL follow this timing: SETUP, 1 cycle, with bus_a and bus_d valid and bus_iow_l=1.
REQ-019 STROBE SHALL drive bus_iow_l=0 for IOW_PULSE cycles, then remain in STROBE while bus_rdy=0.
REQ-020 HOLD SHALL last 1 cycle with bus_iow_l=1 and bus_a/bus_d unchanged.
REQ-021 bus_a and bus_d SHALL change only on entry to SETUP.
REQ-022 The write list SHALL contain 35 entries in this order:
- (0) control at base+8 with bit3 cleared (video off);
- (1..32) for R=0..15: index R to base+4, then table value to base+5;
- (33) color select at base+9;
- (34) control at base+8 with the table value (video enabled).
REQ-023 A 6-bit step counter SHALL index the list, incrementing in NEXT; after step 34 HOLD SHALL go to FINISH.
REQ-024 FINISH SHALL pulse done for 1 cycle, clear busy, and return to IDLE.
REQ-025 A sequence of 35 writes with bus_rdy=1 SHALL take exactly 35*(IOW_PULSE+3) cycles from start acceptance to the done pulse.
REQ-026 The mode table SHALL contain the following values:
- mode 3: control 8'h29, color 8'h30, CRTC 71,50,5A,0A,1F,06,19,1C,02,07,06,07,00,00,00,00 (hex);
- modes 0/1: control 2C/28, color 30, CRTC 38,28,2D,0A,1F,06,19,1C,02,07,06,07,0,0,0,0;
- mode 2: control 2D, color 30, CRTC as mode 3;
- modes 4/5: control 2A/2E, color 30, CRTC 38,28,2D,0A,7F,06,64,70,02,01,06,07,0,0,0,0;
- mode 6: control 1E, color 3F, CRTC as mode 4.
REQ-027 If mode=7 at acceptance, the block SHALL perform no bus cycles, set error, and pulse done 1 cycle later.
REQ-028 bus_a SHALL equal IO_BASE_ADDR[14:0] plus offset; bits above 14 SHALL be ignored.

Reset
REQ-029 On reset the block SHALL force state IDLE and set outputs to: bus_iow_l=1, bus_ior_l=1, bus_aen=1, bus_a=0, bus_d=0, busy=0, done=0, error=0, step=0.
REQ-030 Reset mid-sequence SHALL release bus_iow_l on the next edge, and no done SHALL be produced.

Structure
REQ-031 A shared package cga_pkg SHALL hold the FSM state typedef, the register offsets (4, 5, 8, 9), the constant 35 (write count), and the mode table constant.
REQ-032 One sub-module, cga_mode_rom, SHALL be used: a combinational lookup (mode, step) -> {offset, data}.

Verification
REQ-033 Scenario: start, mode=3, bus_rdy=1, IOW_PULSE=4 -> 35 writes observed; first write is 3D8<=21, then 3D4<=00, 3D5<=71, ...; last write is 3D8<=29; done at cycle 245.
REQ-034 Scenario: bus_rdy low for 10 cycles during write 5 -> bus_iow_l low for 14 cycles on that write, with address and data stable throughout.
REQ-035 Scenario: start while busy -> ignored, and the sequence count stays 35.
REQ-036 Scenario: mode=7 -> no bus_iow_l activity, error=1, done exactly one cycle after acceptance.
REQ-037 Scenario: reset asserted during STROBE of write 10 -> next cycle bus_iow_l=1, busy=0, bus_aen=1, and no done.
REQ-038 Scenario: mode=6 bench with a CGA target model -> control register reads back 1E, color 3F, CRTC R4=7F, R6=64.
